fifo_pop_ctrl: RTL and testbench

Read-side controller for the 6x8 FIFO. Pops words from `fifo_6x8` through its `read`/`data_out_pop` port, absorbs the FIFO's one-cycle read latency in a 3-entry output buffer, and presents the data downstream on a valid/ready handshake. It never underflows the FIFO, stops on FIFO error, and counts delivered words. It sits between the FIFO and the next pipeline stage of the switch datapath.

---
 rtl/fifo_pop_ctrl.sv | 89 ++++++++
 tb/tb_fifo_pop_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: pops the 6x8 FIFO into a 3-entry buffer that hides the FIFO's
// one-cycle read latency and delivers words downstream on valid/ready.
module fifo_pop_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 almost_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [CNT_SIZE-1:0]  pop_count,
    output logic                 err_sticky,
    output logic                 busy,
    output logic                 low_water
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERROR} state_t;
    state_t state, state_next;
    logic [DATA_SIZE-1:0] mem [3];
    logic [1:0] head, tail, occ;
    logic inflight, capture, transfer;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = fifo_error ? ERROR : enable ? RUN : IDLE;
            RUN:     state_next = fifo_error ? ERROR : !enable ? DRAIN : RUN;
            DRAIN:   state_next = fifo_error ? ERROR : enable ? RUN :
                                  (occ == 2'd0 && !inflight) ? IDLE : DRAIN;
            default: state_next = ERROR;
        endcase
    end

    // Counting the in-flight word against free space keeps the buffer from overflowing.
    always_comb begin
        read      = state == RUN && !fifo_empty && ({1'b0, occ} + {2'b00, inflight} < 3'd3);
        valid_out = occ != 2'd0;
        data_out  = mem[head];
        busy      = state != IDLE;
        capture   = inflight;
        transfer  = valid_out && ready_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) mem[i] <= '0;
            head       <= 2'd0;
            tail       <= 2'd0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            pop_count  <= '0;
            err_sticky <= 1'b0;
            low_water  <= 1'b0;
        end else begin
            inflight  <= read;
            low_water <= almost_empty;
            if (fifo_error) err_sticky <= 1'b1;
            if (capture) begin
                mem[tail] <= data_out_pop;
                tail      <= nxt(tail);
            end
            if (transfer) begin
                head      <= nxt(head);
                pop_count <= pop_count + CNT_SIZE'(1);
            end
            if (capture && !transfer)
                occ <= occ + 2'd1;
            else if (!capture && transfer)
                occ <= occ - 2'd1;
        end
    end
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: directed and random stimulus against a queue-based model of
// the FIFO, the outstanding words, and the controller's mode rules.
module tb_fifo_pop_ctrl;
    logic clk = 1'b0;
    logic reset, enable, fifo_empty, almost_empty, fifo_error, ready_in;
    logic [7:0] data_out_pop;
    logic read, valid_out, err_sticky, busy, low_water;
    logic [7:0] data_out;
    logic [15:0] pop_count;
    logic read4, valid_out4, err_sticky4, busy4, low_water4;
    logic [7:0] data_out4;
    logic [3:0] pop_count4;

    always #5 clk = ~clk;

    fifo_pop_ctrl #(.DATA_SIZE(8), .CNT_SIZE(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .almost_empty(almost_empty), .fifo_error(fifo_error), .data_out_pop(data_out_pop),
        .read(read), .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .pop_count(pop_count), .err_sticky(err_sticky), .busy(busy), .low_water(low_water));

    fifo_pop_ctrl #(.DATA_SIZE(8), .CNT_SIZE(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .almost_empty(almost_empty), .fifo_error(fifo_error), .data_out_pop(data_out_pop),
        .read(read4), .data_out(data_out4), .valid_out(valid_out4), .ready_in(ready_in),
        .pop_count(pop_count4), .err_sticky(err_sticky4), .busy(busy4), .low_water(low_water4));

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_ERR} mst_t;
    typedef struct {logic [7:0] d; int t;} rec_t;
    logic [7:0] fq[$];
    rec_t oq[$];
    mst_t mst;
    logic [15:0] m_cnt;
    logic m_err, m_lw;
    int cyc, nreads, checks, failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        fq.delete();
        oq.delete();
        mst = M_IDLE;
        m_cnt = '0;
        m_err = 1'b0;
        m_lw = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic step();
        rec_t e;
        logic rd, vl, xf;
        logic [7:0] w;
        int out0;
        fifo_empty = fq.size() == 0;
        #1;
        out0 = oq.size();
        rd = mst == M_RUN && !fifo_empty && out0 < 3;
        vl = out0 > 0 && oq[0].t <= cyc - 2;
        chk("read", read, rd);
        chk("read4", read4, rd);
        chk("valid_out", valid_out, vl);
        if (vl) chk("data_out", data_out, oq[0].d);
        chk("busy", busy, mst != M_IDLE);
        chk("err_sticky", err_sticky, m_err);
        chk("low_water", low_water, m_lw);
        chk("pop_count", pop_count, m_cnt);
        chk("pop_count4", pop_count4, m_cnt[3:0]);
        if (rd) nreads++;
        xf = vl && ready_in;
        w = 8'h00;
        if (reset) begin
            model_clear();
        end else begin
            if (xf) begin
                void'(oq.pop_front());
                m_cnt++;
            end
            if (rd) begin
                w = fq.pop_front();
                e.d = w;
                e.t = cyc;
                oq.push_back(e);
            end
            m_err |= fifo_error;
            m_lw = almost_empty;
            case (mst)
                M_IDLE:  mst = fifo_error ? M_ERR : enable ? M_RUN : M_IDLE;
                M_RUN:   mst = fifo_error ? M_ERR : !enable ? M_DRAIN : M_RUN;
                M_DRAIN: mst = fifo_error ? M_ERR : enable ? M_RUN : out0 == 0 ? M_IDLE : M_DRAIN;
                default: mst = M_ERR;
            endcase
        end
        @(posedge clk);
        #1;
        data_out_pop = rd ? w : 8'($urandom);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int pushed, n;
        checks = 0; failures = 0; cyc = 100; nreads = 0;
        enable = 0; ready_in = 0; fifo_error = 0; almost_empty = 0; fifo_empty = 1;
        data_out_pop = 8'h00;
        apply_reset();
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_read", read, 1'b0);

        for (int i = 0; i < 6; i++) fq.push_back(8'h11 + 8'(i));
        enable = 1; ready_in = 1; nreads = 0;
        repeat (12) step();
        chk("stream_reads", nreads, 6);
        chk("stream_cnt", pop_count, 6);

        for (int i = 0; i < 6; i++) fq.push_back(8'h40 + 8'(i));
        ready_in = 0; nreads = 0;
        repeat (10) step();
        chk("bp_reads", nreads, 3);
        chk("bp_data", data_out, 8'h40);
        ready_in = 1;
        repeat (12) step();
        chk("bp_cnt", pop_count, 12);

        nreads = 0;
        repeat (20) step();
        chk("empty_reads", nreads, 0);
        fq.push_back(8'hA5);
        repeat (5) step();
        chk("empty_one_read", nreads, 1);

        apply_reset();
        for (int i = 0; i < 6; i++) fq.push_back(8'h60 + 8'(i));
        enable = 1; ready_in = 0; nreads = 0;
        repeat (4) step();
        enable = 0;
        step();
        ready_in = 1;
        repeat (8) step();
        chk("drain_reads", nreads, 3);
        chk("drain_cnt", pop_count, 3);
        chk("drain_busy", busy, 1'b0);

        apply_reset();
        for (int i = 0; i < 6; i++) fq.push_back(8'h80 + 8'(i));
        enable = 1; ready_in = 1;
        repeat (4) step();
        fifo_error = 1;
        step();
        fifo_error = 0;
        repeat (10) step();
        chk("err_sticky_hold", err_sticky, 1'b1);
        enable = 0;
        repeat (5) step();
        enable = 1;
        repeat (5) step();
        chk("err_busy_hold", busy, 1'b1);
        reset = 1;
        step();
        reset = 0;
        chk("err_rst_data", data_out, 8'h00);
        chk("err_rst_sticky", err_sticky, 1'b0);
        enable = 0; fifo_error = 1;
        step();
        fifo_error = 0;
        step();
        chk("idle_err", err_sticky, 1'b1);

        apply_reset();
        enable = 1; ready_in = 1; pushed = 0; n = 0;
        while ((pushed < 17 || oq.size() != 0 || fq.size() != 0) && n < 200) begin
            if (pushed < 17 && fq.size() < 6) begin
                fq.push_back(8'(pushed * 7));
                pushed++;
            end
            step();
            n++;
        end
        chk("wrap_cnt4", pop_count4, 4'd1);
        chk("wrap_cnt16", pop_count, 16'd17);

        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            enable = $urandom_range(0, 9) != 0;
            ready_in = $urandom_range(0, 2) != 0;
            almost_empty = 1'($urandom);
            fifo_error = $urandom_range(0, 499) == 0;
            reset = $urandom_range(0, 299) == 0;
            if (fq.size() < 6 && $urandom_range(0, 2) != 0) fq.push_back(8'($urandom));
            step();
        end
        reset = 0; fifo_error = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
